sbox_serial_seq: RTL and testbench



---
 rtl/sbox_serial_seq.sv | 174 +++++++++++++++++
 tb/tb_sbox_serial_seq.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sbox_serial_seq.sv
// sbox_serial_seq: sequencer that time-shares one combinational AES S-box
// (stablec) across an NBYTES-wide word. A word is accepted over a valid/ready
// handshake, substituted in place one byte per clock, then offered on a
// valid/ready output handshake.
// Optional build macro SBOX_PIPE_EN: registers the S-box input and adds a
// DRAIN state that writes back the final in-flight byte.
module sbox_serial_seq #(
  parameter int NBYTES = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [8*NBYTES-1:0] in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [8*NBYTES-1:0] out_data,
  output logic                busy
);

  localparam int              IDXW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;
`ifdef SBOX_PIPE_EN
  localparam logic [1:0] DRAIN = 2'd3;
`endif

  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // AES S-box: multiplicative inverse (a^254, with 0 -> 0) then the affine map.
  function automatic logic [7:0] stablec(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = a;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
               ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  logic [1:0]      state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [7:0]      data_q [NBYTES];
  logic [7:0]      data_d [NBYTES];
  logic [7:0]      sbox_in;
  logic [7:0]      sbox_out;

`ifdef SBOX_PIPE_EN
  logic [7:0]      pipe_q, pipe_d;
  logic [IDXW-1:0] wb_idx_q, wb_idx_d;
  logic            pvld_q, pvld_d;

  // The registered byte feeds the S-box; its result lands one cycle after issue.
  assign sbox_in = pipe_q;
`else
  assign sbox_in = data_q[idx_q];
`endif

  assign sbox_out = stablec(sbox_in);

  // Handshake and status outputs decode straight from the state register.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);

  // out_data is the working buffer itself; only meaningful while out_valid.
  always_comb begin
    for (int i = 0; i < NBYTES; i++) out_data[8*i +: 8] = data_q[i];
  end

  // Next-state: load on accept, substitute one byte per RUN cycle, hold in DONE.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
`ifdef SBOX_PIPE_EN
    pipe_d   = pipe_q;
    wb_idx_d = wb_idx_q;
    pvld_d   = pvld_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          for (int i = 0; i < NBYTES; i++) data_d[i] = in_data[8*i +: 8];
          idx_d   = '0;
          state_d = RUN;
`ifdef SBOX_PIPE_EN
          pvld_d  = 1'b0;
`endif
        end
      end
      RUN: begin
`ifdef SBOX_PIPE_EN
        // Issue byte idx while retiring the byte issued last cycle.
        pipe_d   = data_q[idx_q];
        wb_idx_d = idx_q;
        pvld_d   = 1'b1;
        if (pvld_q) data_d[wb_idx_q] = sbox_out;
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = DRAIN;
        end else begin
          idx_d = idx_q + 1'b1;
        end
`else
        data_d[idx_q] = sbox_out;
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
`endif
      end
`ifdef SBOX_PIPE_EN
      DRAIN: begin
        data_d[wb_idx_q] = sbox_out;
        pvld_d           = 1'b0;
        state_d          = DONE;
      end
`endif
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, index and buffer registers; reset aborts any word in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      for (int i = 0; i < NBYTES; i++) data_q[i] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
    end
  end

`ifdef SBOX_PIPE_EN
  // Pipeline register between the byte mux and the S-box input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_q   <= '0;
      wb_idx_q <= '0;
      pvld_q   <= 1'b0;
    end else begin
      pipe_q   <= pipe_d;
      wb_idx_q <= wb_idx_d;
      pvld_q   <= pvld_d;
    end
  end
`endif

endmodule

// File: tb/tb_sbox_serial_seq.sv
// tb_sbox_serial_seq: scoreboard bench for sbox_serial_seq with a 4-byte and a
// 16-byte instance. Expected words come from an S-box table generated inside
// the bench (generator/inverse-walk method) or from known vector constants.
module tb_sbox_serial_seq;

`ifdef SBOX_PIPE_EN
  localparam int PIPE = 1;
`else
  localparam int PIPE = 0;
`endif
  localparam int LAT4  = 4 + PIPE;
  localparam int LAT16 = 16 + PIPE;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         iv4, ir4, ov4, or4, busy4;
  logic [31:0]  id4, od4;
  logic         iv16, ir16, ov16, or16, busy16;
  logic [127:0] id16, od16;

  sbox_serial_seq #(.NBYTES(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv4), .in_ready(ir4), .in_data(id4),
    .out_valid(ov4), .out_ready(or4), .out_data(od4), .busy(busy4)
  );

  sbox_serial_seq #(.NBYTES(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv16), .in_ready(ir16), .in_data(id16),
    .out_valid(ov16), .out_ready(or16), .out_data(od16), .busy(busy16)
  );

  int ncmp  = 0;
  int nfail = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference S-box table, built by walking the multiplicative group with
  // generator 3 and tracking its inverse, then applying the affine map.
  logic [7:0] sbt [256];

  task automatic build_table();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sbt[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbt[0] = 8'h63;
  endtask

  function automatic logic [31:0] ref4(input logic [31:0] w);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = sbt[w[8*i +: 8]];
    return r;
  endfunction

  // Scoreboard state: expected words, accept cycles, accepted/retired counts.
  logic [31:0]  exp4  [$];
  int           at4   [$];
  int           acc4  = 0;
  int           done4 = 0;
  logic         pov4  = 1'b0;
  logic [127:0] exp16 [$];
  int           at16  [$];
  int           acc16 = 0;
  int           done16 = 0;
  logic         pov16 = 1'b0;

  // Monitor for the 4-byte instance: status, data stability, latency, pops.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp4.delete();
      at4.delete();
      done4 = acc4;
      pov4  = 1'b0;
    end else begin
      chk("busy4", {127'd0, busy4}, {127'd0, acc4 != done4});
      chk("in_ready4", {127'd0, ir4}, {127'd0, acc4 == done4});
      if (ov4) begin
        if (exp4.size() == 0) begin
          chk("unexpected_out4", {127'd0, ov4}, 128'd0);
        end else begin
          chk("data4", {96'd0, od4}, {96'd0, exp4[0]});
          if (!pov4) chk("latency4", 128'(cyc - at4[0]), 128'(LAT4));
          if (or4) begin
            void'(exp4.pop_front());
            void'(at4.pop_front());
            done4++;
          end
        end
      end
      pov4 = ov4;
    end
  end

  // Monitor for the 16-byte instance.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp16.delete();
      at16.delete();
      done16 = acc16;
      pov16  = 1'b0;
    end else begin
      chk("busy16", {127'd0, busy16}, {127'd0, acc16 != done16});
      if (ov16) begin
        if (exp16.size() == 0) begin
          chk("unexpected_out16", {127'd0, ov16}, 128'd0);
        end else begin
          chk("data16", od16, exp16[0]);
          if (!pov16) chk("latency16", 128'(cyc - at16[0]), 128'(LAT16));
          if (or16) begin
            void'(exp16.pop_front());
            void'(at16.pop_front());
            done16++;
          end
        end
      end
      pov16 = ov16;
    end
  end

  // Inputs change just after the rising edge, stable until the next one.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send4(input logic [31:0] d, input logic [31:0] e, output int t);
    int n;
    n = 0;
    t = -1;
    tick();
    iv4 = 1'b1;
    id4 = d;
    while (!ir4 && n < 200) begin
      tick();
      n++;
    end
    if (!ir4) begin
      chk("send4_ready", {127'd0, ir4}, 128'd1);
    end else begin
      exp4.push_back(e);
      at4.push_back(cyc + 1);
      t = cyc + 1;
      @(posedge clk);
      acc4++;
    end
    #1 iv4 = 1'b0;
  endtask

  task automatic send16(input logic [127:0] d, input logic [127:0] e);
    int n;
    n = 0;
    tick();
    iv16 = 1'b1;
    id16 = d;
    while (!ir16 && n < 200) begin
      tick();
      n++;
    end
    if (!ir16) begin
      chk("send16_ready", {127'd0, ir16}, 128'd1);
    end else begin
      exp16.push_back(e);
      at16.push_back(cyc + 1);
      @(posedge clk);
      acc16++;
    end
    #1 iv16 = 1'b0;
  endtask

  task automatic wait_idle4();
    int n;
    n = 0;
    while (done4 != acc4 && n < 300) begin
      tick();
      n++;
    end
    chk("drain4", 128'(acc4 - done4), 128'd0);
  endtask

  task automatic wait_idle16();
    int n;
    n = 0;
    while (done16 != acc16 && n < 300) begin
      tick();
      n++;
    end
    chk("drain16", 128'(acc16 - done16), 128'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int t1, t2, n;
    logic rnd_done;
    build_table();
    rst_n = 1'b0;
    iv4 = 1'b0; id4 = '0; or4 = 1'b1;
    iv16 = 1'b0; id16 = '0; or16 = 1'b1;

    // Reset values while rst_n is low.
    #12;
    chk("rst_ov4", {127'd0, ov4}, 128'd0);
    chk("rst_od4", {96'd0, od4}, 128'd0);
    chk("rst_busy4", {127'd0, busy4}, 128'd0);
    chk("rst_od16", od16, 128'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Idle for 20 cycles with in_valid low: nothing changes.
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle_ready4", {127'd0, ir4}, 128'd1);
      chk("idle_ov4", {127'd0, ov4}, 128'd0);
      chk("idle_od4", {96'd0, od4}, 128'd0);
      chk("idle_ready16", {127'd0, ir16}, 128'd1);
    end

    // Known 4-byte vector.
    send4(32'h53020100, 32'hed777c63, t1);
    wait_idle4();

    // Known 16-byte vectors.
    send16({16{8'h00}}, {16{8'h63}});
    wait_idle16();
    send16({16{8'hff}}, {16{8'h16}});
    wait_idle16();

    // Backpressure: output held, spurious input ignored.
    tick();
    or4 = 1'b0;
    send4(32'hdeadbeef, ref4(32'hdeadbeef), t1);
    n = 0;
    while (!ov4 && n < 50) begin
      tick();
      n++;
    end
    chk("bp_wait_ov4", {127'd0, ov4}, 128'd1);
    for (int i = 0; i < 10; i++) begin
      tick();
      iv4 = 1'b1;
      id4 = $urandom;
      chk("bp_ov4", {127'd0, ov4}, 128'd1);
      chk("bp_ready4", {127'd0, ir4}, 128'd0);
    end
    tick();
    iv4 = 1'b0;
    or4 = 1'b1;
    tick();
    chk("bp_release_ov4", {127'd0, ov4}, 128'd0);
    chk("bp_release_ready4", {127'd0, ir4}, 128'd1);

    // Reset after two of four bytes have been substituted.
    send4(32'h12345678, ref4(32'h12345678), t1);
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_ov4", {127'd0, ov4}, 128'd0);
    chk("midrst_od4", {96'd0, od4}, 128'd0);
    chk("midrst_busy4", {127'd0, busy4}, 128'd0);
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    send4(32'h000000ff, 32'h63636316, t1);
    wait_idle4();

    // Back-to-back with out_ready high.
    send4(32'h00000001, 32'h6363637c, t1);
    send4(32'h00000002, 32'h63636377, t2);
    chk("b2b_spacing", 128'(t2 - t1), 128'(6 + PIPE));
    wait_idle4();

    // Randomized words with random backpressure.
    rnd_done = 1'b0;
    fork
      begin
        logic [31:0] d;
        int t;
        for (int i = 0; i < 40; i++) begin
          d = $urandom;
          send4(d, ref4(d), t);
          repeat ($urandom_range(0, 3)) tick();
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          tick();
          or4 = ($urandom_range(0, 3) != 0);
        end
        or4 = 1'b1;
      end
    join
    wait_idle4();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
